// File: rtl/pixel_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pixel_wb_pkg
// Brief   : Shared constants for the pixel macro Wishbone initiator.
// Revision: 1.0
// ============================================================================
package pixel_wb_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RSP  = 2'd2;

  localparam logic [31:0] PIXEL_CTRL_BASE = 32'h3000_0000;
  localparam logic [7:0]  CTRL_REG_OFF    = 8'h00;

  // Layout of the 25-bit pixel control word behind CTRL_REG_OFF
  localparam int CTRL_W      = 25;
  localparam int START_BIT   = 0;
  localparam int DONE_BIT    = 1;
  localparam int LOC_M_BIT   = 2;
  localparam int ADJ_M_BIT   = 3;
  localparam int LOC_MAX_LSB = 4;
  localparam int LOC_MAX_MSB = 13;
  localparam int ADJ_MAX_LSB = 14;
  localparam int ADJ_MAX_MSB = 23;

  function automatic int cmd_width(input int off_w);
    return 1 + off_w + 4 + 32;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module  : pixel_cmd_fifo
// Brief   : Synchronous command FIFO with full/empty flags, no bypass path.
// Revision: 1.0
// ============================================================================
module pixel_cmd_fifo #(
  parameter int WIDTH = 45,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_wr;
  logic             w_rd;

  assign w_wr = i_push && !o_full;
  assign w_rd = i_pop && !o_empty;

  // Extra pointer MSB distinguishes full from empty
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_data  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/pixel_wb_master.sv
`default_nettype none
// ============================================================================
// Module  : pixel_wb_master
// Brief   : Wishbone classic initiator, one bus cycle per queued command.
// Revision: 1.0
// ============================================================================
module pixel_wb_master
  import pixel_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = PIXEL_CTRL_BASE,
  parameter int          OFF_W       = 8,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          TIMEOUT_CYC = 255
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_we_i,
  input  logic [OFF_W-1:0] cmd_adr_i,
  input  logic [3:0]       cmd_sel_i,
  input  logic [31:0]      cmd_dat_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_dat_o,
  output logic             rsp_err_o,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  input  logic [31:0]      wbm_dat_i,
  input  logic             wbm_ack_i,
  output logic             busy_o
);

  localparam int CMD_W = cmd_width(OFF_W);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_head_vld;
  logic             r_cyc;
  logic             r_we;
  logic [3:0]       r_sel;
  logic [31:0]      r_adr;
  logic [31:0]      r_dat;
  logic             r_rsp_valid;
  logic [31:0]      r_rsp_dat;
  logic             r_rsp_err;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_launch;
  logic             w_timeout;
  logic [CMD_W-1:0] w_fifo_din;
  logic [CMD_W-1:0] w_fifo_dout;
  logic             w_head_we;
  logic [OFF_W-1:0] w_head_adr;
  logic [3:0]       w_head_sel;
  logic [31:0]      w_head_dat;

  assign w_push     = cmd_valid_i && !w_full;
  assign w_fifo_din = {cmd_we_i, cmd_adr_i, cmd_sel_i, cmd_dat_i};

  assign w_head_we  = w_fifo_dout[CMD_W-1];
  assign w_head_adr = w_fifo_dout[CMD_W-2 -: OFF_W];
  assign w_head_sel = w_fifo_dout[35:32];
  assign w_head_dat = w_fifo_dout[31:0];

  pixel_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .i_push  (w_push),
    .i_data  (w_fifo_din),
    .i_pop   (w_launch),
    .o_data  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Head entry must have been present for a full cycle before it launches
  assign w_launch  = (r_state == ST_IDLE) && !w_empty && r_head_vld;
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_head_vld  <= 1'b0;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_sel       <= '0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_head_vld <= !w_empty;
      case (r_state)
        ST_IDLE: begin
          if (w_launch) begin
            r_state <= ST_REQ;
            r_cyc   <= 1'b1;
            r_we    <= w_head_we;
            r_sel   <= w_head_sel;
            r_adr   <= BASE_ADDR | 32'(w_head_adr);
            r_dat   <= w_head_dat;
          end
        end
        ST_REQ: begin
          if (wbm_ack_i || w_timeout) begin
            // ack has priority over a coincident timeout
            r_state     <= ST_RSP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= !wbm_ack_i;
            r_rsp_dat   <= (wbm_ack_i && !r_we) ? wbm_dat_i : 32'd0;
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_sel       <= '0;
            r_adr       <= '0;
            r_dat       <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_RSP: begin
          if (rsp_ready_i) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= '0;
            r_rsp_err   <= 1'b0;
            r_cnt       <= '0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready_o = !w_full;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_dat_o   = r_rsp_dat;
  assign rsp_err_o   = r_rsp_err;
  assign wbm_cyc_o   = r_cyc;
  assign wbm_stb_o   = r_cyc;
  assign wbm_we_o    = r_we;
  assign wbm_sel_o   = r_sel;
  assign wbm_adr_o   = r_adr;
  assign wbm_dat_o   = r_dat;
  assign busy_o      = !w_empty || (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_pixel_wb_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_pixel_wb_master
// Brief   : Directed self-checking bench for pixel_wb_master.
// Revision: 1.0
// ============================================================================
module tb_pixel_wb_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [7:0]  cmd_adr;
  logic [3:0]  cmd_sel;
  logic [31:0] cmd_dat;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic [31:0] rdat;
  logic        ack;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pixel_wb_master #(
    .BASE_ADDR   (32'h3000_0000),
    .OFF_W       (8),
    .FIFO_DEPTH  (4),
    .TIMEOUT_CYC (8)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_we_i    (cmd_we),
    .cmd_adr_i   (cmd_adr),
    .cmd_sel_i   (cmd_sel),
    .cmd_dat_i   (cmd_dat),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_dat_o   (rsp_dat),
    .rsp_err_o   (rsp_err),
    .wbm_cyc_o   (cyc),
    .wbm_stb_o   (stb),
    .wbm_we_o    (we),
    .wbm_sel_o   (sel),
    .wbm_adr_o   (adr),
    .wbm_dat_o   (wdat),
    .wbm_dat_i   (rdat),
    .wbm_ack_i   (ack),
    .busy_o      (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic w, input logic [7:0] a, input logic [3:0] s, input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_we    = w;
    cmd_adr   = a;
    cmd_sel   = s;
    cmd_dat   = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_stb();
    for (int c = 0; c < 20 && !stb; c++) tick();
    chk("wait_stb", {31'd0, stb}, 32'd1);
  endtask

  initial begin
    int   n;
    int   idx;
    int   cnt;
    logic acc;

    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_sel = '0;
    cmd_dat = '0; rsp_ready = 1'b1; rdat = '0; ack = 1'b0;
    tick(); tick(); tick();
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_cyc",   {31'd0, cyc},       32'd0);
    chk("rst_rspv",  {31'd0, rsp_valid}, 32'd0);
    chk("rst_busy",  {31'd0, busy},      32'd0);
    chk("rst_adr",   adr,                32'd0);
    rst = 1'b0;
    tick();

    // Write: push at edge0, stb after edge2, response after edge3, idle after edge4
    push(1'b1, 8'h00, 4'hF, 32'h0000_5021);
    chk("w_busy", {31'd0, busy}, 32'd1);
    chk("w_cyc0", {31'd0, cyc},  32'd0);
    tick();
    chk("w_cyc1", {31'd0, cyc},  32'd0);
    tick();
    chk("w_stb",  {31'd0, stb},  32'd1);
    chk("w_we",   {31'd0, we},   32'd1);
    chk("w_adr",  adr,           32'h3000_0000);
    chk("w_sel",  {28'd0, sel},  32'hF);
    chk("w_dat",  wdat,          32'h0000_5021);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("w_rspv", {31'd0, rsp_valid}, 32'd1);
    chk("w_err",  {31'd0, rsp_err},   32'd0);
    chk("w_rdat", rsp_dat,            32'd0);
    chk("w_cycd", {31'd0, cyc},       32'd0);
    chk("w_adr0", adr,                32'd0);
    tick();
    chk("w_rspc", {31'd0, rsp_valid}, 32'd0);
    chk("w_idle", {31'd0, busy},      32'd0);

    // Read acked on the second strobe cycle
    push(1'b0, 8'h04, 4'h3, 32'hFFFF_FFFF);
    tick(); tick();
    chk("r_stb", {31'd0, stb}, 32'd1);
    chk("r_we",  {31'd0, we},  32'd0);
    chk("r_adr", adr,          32'h3000_0004);
    tick();
    chk("r_stb2", {31'd0, stb}, 32'd1);
    ack = 1'b1; rdat = 32'h00AB_CDEF;
    tick();
    ack = 1'b0; rdat = '0;
    chk("r_rspv", {31'd0, rsp_valid}, 32'd1);
    chk("r_dat",  rsp_dat,            32'h00AB_CDEF);
    chk("r_err",  {31'd0, rsp_err},   32'd0);
    chk("r_stbd", {31'd0, stb},       32'd0);
    tick();

    // Timeout: no ack, strobe for exactly TIMEOUT_CYC cycles
    push(1'b0, 8'h10, 4'hF, 32'd0);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      if (stb) cnt++;
      if (rsp_valid) break;
      tick();
    end
    chk("to_rspv", {31'd0, rsp_valid}, 32'd1);
    chk("to_cnt",  cnt,                32'd8);
    chk("to_err",  {31'd0, rsp_err},   32'd1);
    chk("to_dat",  rsp_dat,            32'd0);
    tick();

    // Ack in the final allowed cycle beats the timeout
    push(1'b0, 8'h14, 4'hF, 32'd0);
    wait_stb();
    repeat (7) tick();
    chk("ta_stb", {31'd0, stb}, 32'd1);
    ack = 1'b1; rdat = 32'h1234_5678;
    tick();
    ack = 1'b0; rdat = '0;
    chk("ta_rspv", {31'd0, rsp_valid}, 32'd1);
    chk("ta_err",  {31'd0, rsp_err},   32'd0);
    chk("ta_dat",  rsp_dat,            32'h1234_5678);
    tick();

    // Pending response with rsp_ready low blocks the FIFO; fill it
    rsp_ready = 1'b0;
    push(1'b1, 8'h40, 4'hF, 32'hAAAA_5555);
    wait_stb();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 8'(8'h20 + 4 * i);
      cmd_sel = 4'hF; cmd_dat = 32'(i);
      tick();
    end
    chk("f_full", {31'd0, cmd_ready}, 32'd0);
    cmd_adr = 8'h30; cmd_dat = 32'd4;
    for (int i = 0; i < 10; i++) begin
      chk("h_rspv",  {31'd0, rsp_valid}, 32'd1);
      chk("h_dat",   rsp_dat,            32'd0);
      chk("h_cyc",   {31'd0, cyc},       32'd0);
      chk("h_ready", {31'd0, cmd_ready}, 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    n = 0; idx = 0;
    for (int c = 0; c < 100 && n < 6; c++) begin
      acc = cmd_valid && cmd_ready;
      if (stb) begin
        chk("q_adr", adr, 32'h3000_0020 + 32'(4 * idx));
        idx++;
      end
      ack = stb;
      if (rsp_valid) n++;
      tick();
      if (acc) cmd_valid = 1'b0;
    end
    ack = 1'b0;
    chk("q_cmds", idx, 32'd5);
    chk("q_rsps", n,   32'd6);
    chk("q_idle", {31'd0, busy}, 32'd0);

    // Reset mid-REQ with a second command queued, then stray acks
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 8'h50; cmd_sel = 4'hF;
    tick();
    cmd_adr = 8'h54;
    tick();
    cmd_valid = 1'b0;
    wait_stb();
    rst = 1'b1; ack = 1'b1;
    tick();
    chk("x_cyc",   {31'd0, cyc},       32'd0);
    chk("x_stb",   {31'd0, stb},       32'd0);
    chk("x_rspv",  {31'd0, rsp_valid}, 32'd0);
    chk("x_busy",  {31'd0, busy},      32'd0);
    chk("x_ready", {31'd0, cmd_ready}, 32'd1);
    rst = 1'b0;
    tick(); tick();
    chk("s_rspv", {31'd0, rsp_valid}, 32'd0);
    chk("s_cyc",  {31'd0, cyc},       32'd0);
    chk("s_busy", {31'd0, busy},      32'd0);
    ack = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
